branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_pkg.sv | 17 +
 rtl/branch_compare.sv | 26 ++
 rtl/branch_resolve_unit.sv | 117 +++++++++++
 tb/tb_branch_resolve_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: funct3 encodings and FSM states.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation; reserved funct3 codes resolve not-taken.
module branch_compare
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches in the execute stage, issues a target redirect to fetch and
// holds a flush window afterwards. All outputs are registered.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16,
    parameter logic [1:0]  EXEC_STAGE   = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       stage,
    input  logic             br_valid,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             misalign_err,
    output logic             busy,
    output logic [CNT_W-1:0] taken_count
);

    localparam int unsigned FC_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned FLUSH_LOAD = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [XLEN-1:0]   redirect_pc_d;
    logic [CNT_W-1:0]  taken_count_d;
    logic              misalign_d;
    logic              taken_c;
    logic              accept_c;
    logic [XLEN-1:0]   target_c;

    branch_compare #(.XLEN(XLEN)) u_compare (
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .taken  (taken_c)
    );

    assign target_c = pc + imm;
    assign accept_c = (stage == EXEC_STAGE) && br_valid;

    // Next-state and next-output logic; flush counter counts down remaining flush cycles.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        redirect_pc_d = redirect_pc;
        taken_count_d = taken_count;
        misalign_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c && taken_c) begin
                    if (target_c[1:0] == 2'b00) begin
                        state_d       = ST_REDIRECT;
                        redirect_pc_d = target_c;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    if (taken_count != CNT_MAX) begin
                        taken_count_d = taken_count + CNT_W'(1);
                    end
                    if (FLUSH_CYCLES > 0) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FC_W'(FLUSH_LOAD);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; status outputs mirror the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            flush_cnt_q    <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            misalign_err   <= 1'b0;
            busy           <= 1'b0;
            taken_count    <= '0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            redirect_valid <= (state_d == ST_REDIRECT);
            redirect_pc    <= redirect_pc_d;
            flush          <= (state_d == ST_FLUSH);
            misalign_err   <= misalign_d;
            busy           <= (state_d != ST_IDLE);
            taken_count    <= taken_count_d;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a transaction-level reference model
// checked every cycle, plus literal expectations at key points.
module tb_branch_resolve_unit;

    localparam int XLEN = 32;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       stage;
    logic             br_valid;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  rs1, rs2, pc, imm;
    logic             redirect_valid;
    logic             redirect_ready;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;
    logic             misalign_err;
    logic             busy;
    logic [CNT_W-1:0] taken_count;

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolve_unit #(
        .XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W), .EXEC_STAGE(2'b01)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stage(stage), .br_valid(br_valid), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .flush(flush), .misalign_err(misalign_err),
        .busy(busy), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an outstanding redirect, a remaining flush-cycle budget, a count.
    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa = int'(a);
        int sb = int'(b);
        case (f3)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return sa < sb;
            3'b101: return !(sa < sb);
            3'b110: return a < b;
            3'b111: return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    bit          m_pending;
    logic [31:0] m_target;
    int          m_flush_left;
    bit          m_misalign;
    int          m_count;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] t;
        if (!rst_n) begin
            m_pending = 0; m_target = 0; m_flush_left = 0; m_misalign = 0; m_count = 0;
        end else begin
            m_misalign = 0;
            if (m_pending) begin
                if (redirect_ready) begin
                    m_pending = 0;
                    if (m_count < 65535) m_count++;
                    m_flush_left = FLUSH_CYCLES;
                end
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (stage == 2'b01 && br_valid && ref_taken(funct3, rs1, rs2)) begin
                t = pc + imm;
                if (t % 4 == 0) begin
                    m_pending = 1;
                    m_target  = t;
                end else begin
                    m_misalign = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("m_redirect_valid", 64'(redirect_valid), 64'(m_pending));
        if (m_pending) check("m_redirect_pc", 64'(redirect_pc), 64'(m_target));
        check("m_flush", 64'(flush), 64'(m_flush_left > 0));
        check("m_busy", 64'(busy), 64'(m_pending || m_flush_left > 0));
        check("m_misalign", 64'(misalign_err), 64'(m_misalign));
        check("m_taken_count", 64'(taken_count), 64'(m_count));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input logic [31:0] i);
        br_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = i;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stage = 2'b01; br_valid = 1'b0; funct3 = 3'b000;
        rs1 = '0; rs2 = '0; pc = '0; imm = '0; redirect_ready = 1'b0;
        step(); step();
        @(negedge clk);
        check("reset_outputs", {redirect_valid, flush, misalign_err, busy}, 4'b0000);
        check("reset_pc", 64'(redirect_pc), 64'h0);
        check("reset_count", 64'(taken_count), 64'h0);
        step();
        rst_n = 1'b1;

        // Signed BLT taken, immediate handshake, two flush cycles.
        redirect_ready = 1'b1;
        set_br(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);
        step();
        br_valid = 1'b0;
        @(negedge clk);
        check("blt_valid", 64'(redirect_valid), 64'h1);
        check("blt_pc", 64'(redirect_pc), 64'h120);
        step();
        @(negedge clk);
        check("blt_flush1", 64'(flush), 64'h1);
        check("blt_count", 64'(taken_count), 64'h1);
        step();
        @(negedge clk);
        check("blt_flush2", 64'(flush), 64'h1);
        step();
        @(negedge clk);
        check("blt_idle", {flush, busy}, 2'b00);

        // Unsigned compare of the same operands is not taken.
        step();
        set_br(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);
        step();
        br_valid = 1'b0;
        @(negedge clk);
        check("bltu_quiet", {redirect_valid, flush, busy}, 3'b000);

        // Reserved funct3 never redirects.
        set_br(3'b010, 32'h5, 32'h5, 32'h100, 32'h20);
        step();
        br_valid = 1'b0;
        @(negedge clk);
        check("f3_010_quiet", {redirect_valid, busy}, 2'b00);

        // Taken but misaligned target: one-cycle error pulse only.
        set_br(3'b000, 32'h5, 32'h5, 32'h100, 32'h6);
        step();
        br_valid = 1'b0;
        @(negedge clk);
        check("beq_misalign", {misalign_err, redirect_valid, busy}, 3'b100);
        step();
        @(negedge clk);
        check("beq_misalign_end", 64'(misalign_err), 64'h0);
        check("beq_count", 64'(taken_count), 64'h1);

        // BNE with fetch back-pressure; a second branch during the wait is ignored.
        redirect_ready = 1'b0;
        set_br(3'b001, 32'h1, 32'h2, 32'h100, 32'h20);
        step();
        set_br(3'b000, 32'h7, 32'h7, 32'h200, 32'h40);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bne_hold", {redirect_valid, busy}, 2'b11);
            check("bne_hold_pc", 64'(redirect_pc), 64'h120);
            step();
        end
        br_valid = 1'b0;
        redirect_ready = 1'b1;
        step();
        @(negedge clk);
        check("bne_count", 64'(taken_count), 64'h2);
        step(); step();
        @(negedge clk);
        check("bne_done", 64'(busy), 64'h0);

        // Target wraps modulo 2^32; reset asserted mid-flush.
        set_br(3'b101, 32'h3, 32'h3, 32'hFFFF_FFF0, 32'h20);
        step();
        br_valid = 1'b0;
        @(negedge clk);
        check("bge_wrap_pc", 64'(redirect_pc), 64'h10);
        step();
        @(negedge clk);
        check("bge_flush", 64'(flush), 64'h1);
        check("bge_count", 64'(taken_count), 64'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {redirect_valid, flush, misalign_err, busy}, 4'b0000);
        check("async_reset_count", 64'(taken_count), 64'h0);
        step();
        rst_n = 1'b1;

        // Branch held through the flush window is accepted right after it ends.
        set_br(3'b111, 32'h5, 32'h3, 32'h0, 32'h8);
        step();
        @(negedge clk);
        check("post_reset_accept", 64'(redirect_valid), 64'h1);
        check("post_reset_pc", 64'(redirect_pc), 64'h8);
        for (int k = 0; k < 5; k++) step();
        br_valid = 1'b0;
        step(); step();
        @(negedge clk);
        check("reaccept_count", 64'(taken_count), 64'h2);
        check("reaccept_idle", 64'(busy), 64'h0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
